// File: rtl/cpu_bus_bridge.sv
// cpu_bus_bridge: turns the CPU request strobe into a decoded, held access
// to one of four peripheral targets. It enforces a minimum wait-state count
// and a no-ack timeout, returns read data with a one-cycle ready pulse, and
// buffers one request that arrives while busy.
module cpu_bus_bridge #(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter int unsigned TIMEOUT     = 16,
   parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
   input  logic        i_cpu_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_err,
   output logic        o_busy,
   output logic        o_overrun,
   output logic [3:0]  o_per_sel,
   output logic        o_per_we,
   output logic [27:0] o_per_addr,
   output logic [31:0] o_per_wdata,
   input  logic [31:0] i_per_rdata,
   input  logic        i_per_ack
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   localparam logic [7:0] WAIT_C  = 8'(WAIT_CYCLES);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic        req_dly_q;
   logic [7:0]  cnt_q;
   logic        pend_v_q;
   logic        pend_we_q;
   logic [31:0] pend_addr_q;
   logic [31:0] pend_wdata_q;
   logic        cap_we_q;
   logic [27:0] cap_addr_q;
   logic [31:0] cap_wdata_q;
   logic [3:0]  sel_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        ready_q;
   logic        overrun_q;

   logic        start_edge;
   logic        consume;
   logic        take;
   logic        src_we_d;
   logic [31:0] src_addr_d;
   logic [31:0] src_wdata_d;
   logic        mapped;
   logic [3:0]  sel_d;
   logic        ack_ok;
   logic        timed_out;

   // Request edge detect and selection of the transaction source for IDLE.
   // The pending slot takes priority over a fresh edge in IDLE.
   always_comb begin
      start_edge  = i_req & ~req_dly_q;
      consume     = (state_q == S_IDLE) & pend_v_q;
      take        = consume | ((state_q == S_IDLE) & start_edge);
      src_we_d    = pend_v_q ? pend_we_q    : i_we;
      src_addr_d  = pend_v_q ? pend_addr_q  : i_addr;
      src_wdata_d = pend_v_q ? pend_wdata_q : i_wdata;
      mapped      = (src_addr_d[31:30] == 2'b00);
      sel_d       = 4'b0001 << src_addr_d[29:28];
      ack_ok      = (cnt_q >= WAIT_C) & i_per_ack;
      timed_out   = (cnt_q == TO_LAST);
   end

   // Transaction FSM, wait/timeout counter, completion outputs and pending slot.
   always_ff @(posedge i_cpu_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         req_dly_q    <= 1'b1;
         cnt_q        <= '0;
         pend_v_q     <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_wdata_q <= '0;
         cap_we_q     <= 1'b0;
         cap_addr_q   <= '0;
         cap_wdata_q  <= '0;
         sel_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         ready_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         req_dly_q <= i_req;
         ready_q   <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (take) begin
                  if (mapped) begin
                     cap_we_q    <= src_we_d;
                     cap_addr_q  <= src_addr_d[27:0];
                     cap_wdata_q <= src_wdata_d;
                     sel_q       <= sel_d;
                     cnt_q       <= '0;
                     state_q     <= S_ACCESS;
                  end else begin
                     rdata_q <= ERR_DATA;
                     err_q   <= 1'b1;
                     ready_q <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_ACCESS: begin
               if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
               if (ack_ok) begin
                  rdata_q <= cap_we_q ? '0 : i_per_rdata;
                  err_q   <= 1'b0;
                  ready_q <= 1'b1;
                  sel_q   <= '0;
                  state_q <= S_DONE;
               end else if (timed_out) begin
                  rdata_q <= ERR_DATA;
                  err_q   <= 1'b1;
                  ready_q <= 1'b1;
                  sel_q   <= '0;
                  state_q <= S_DONE;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase

         // An edge that is not taken directly goes to the slot; the slot can
         // be refilled in the same cycle it is consumed.
         if (start_edge && ((state_q != S_IDLE) || consume)) begin
            if (!pend_v_q || consume) begin
               pend_v_q     <= 1'b1;
               pend_we_q    <= i_we;
               pend_addr_q  <= i_addr;
               pend_wdata_q <= i_wdata;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (consume) begin
            pend_v_q <= 1'b0;
         end
      end
   end

   assign o_rdata     = rdata_q;
   assign o_ready     = ready_q;
   assign o_err       = err_q;
   assign o_busy      = (state_q != S_IDLE) | pend_v_q;
   assign o_overrun   = overrun_q;
   assign o_per_sel   = sel_q;
   assign o_per_we    = cap_we_q;
   assign o_per_addr  = cap_addr_q;
   assign o_per_wdata = cap_wdata_q;

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Testbench for cpu_bus_bridge: per-cycle vector table on a WAIT_CYCLES=1
// instance, plus hand-written sequences for early-ack, overrun and reset.
module tb_cpu_bus_bridge;

   logic        clk = 1'b0;
   logic        rst, req, we, ack;
   logic [31:0] addr, wdata, prdata;

   logic [31:0] rdata0, pwdata0, rdata1, pwdata1;
   logic        ready0, err0, busy0, ovr0, pwe0;
   logic        ready1, err1, busy1, ovr1, pwe1;
   logic [3:0]  sel0, sel1;
   logic [27:0] paddr0, paddr1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cpu_bus_bridge #(.WAIT_CYCLES(1), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) u0 (
      .i_cpu_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .o_rdata(rdata0), .o_ready(ready0), .o_err(err0),
      .o_busy(busy0), .o_overrun(ovr0), .o_per_sel(sel0), .o_per_we(pwe0),
      .o_per_addr(paddr0), .o_per_wdata(pwdata0), .i_per_rdata(prdata),
      .i_per_ack(ack));

   cpu_bus_bridge #(.WAIT_CYCLES(2), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) u1 (
      .i_cpu_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .o_rdata(rdata1), .o_ready(ready1), .o_err(err1),
      .o_busy(busy1), .o_overrun(ovr1), .o_per_sel(sel1), .o_per_we(pwe1),
      .o_per_addr(paddr1), .o_per_wdata(pwdata1), .i_per_rdata(prdata),
      .i_per_ack(ack));

   typedef struct {
      logic        rst, req, we;
      logic [31:0] addr, wdata, prdata;
      logic        ack;
      logic        e_ready, e_err, e_busy;
      logic [3:0]  e_sel;
      logic [31:0] e_rdata;
      logic [27:0] e_paddr;
      logic        e_pwe;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic r, input logic q, input logic w,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] pr, input logic k,
                               input logic erdy, input logic eerr, input logic ebusy,
                               input logic [3:0] esel, input logic [31:0] erd,
                               input logic [27:0] epa, input logic epwe);
      vec_t v;
      v.rst = r; v.req = q; v.we = w; v.addr = a; v.wdata = wd; v.prdata = pr; v.ack = k;
      v.e_ready = erdy; v.e_err = eerr; v.e_busy = ebusy; v.e_sel = esel;
      v.e_rdata = erd; v.e_paddr = epa; v.e_pwe = epwe;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      rst = 1'b1; req = 1'b0; we = 1'b0; ack = 1'b0;
      addr = '0; wdata = '0; prdata = '0;

      // Each record: inputs for one cycle, outputs expected after the next edge.
      add(1,0,0,32'h0,32'h0,32'h0,0,          0,0,0,4'b0000,32'h0,28'h0,0);
      add(0,0,0,32'h0,32'h0,32'h0,0,          0,0,0,4'b0000,32'h0,28'h0,0);
      // unmapped read: DONE one cycle after the edge
      add(0,1,0,32'h7000_0000,32'h0,32'h0,0,  1,1,1,4'b0000,32'hDEADBEEF,28'h0,0);
      add(0,0,0,32'h7000_0000,32'h0,32'h0,0,  0,1,0,4'b0000,32'hDEADBEEF,28'h0,0);
      // read target 2, ack held high
      add(0,1,0,32'h2000_0010,32'h0,32'h1234_5678,1, 0,1,1,4'b0100,32'hDEADBEEF,28'h10,0);
      add(0,1,0,32'h2000_0010,32'h0,32'h1234_5678,1, 0,1,1,4'b0100,32'hDEADBEEF,28'h10,0);
      add(0,1,0,32'h2000_0010,32'h0,32'h1234_5678,1, 1,0,1,4'b0000,32'h1234_5678,28'h10,0);
      add(0,0,0,32'h2000_0010,32'h0,32'h1234_5678,0, 0,0,0,4'b0000,32'h1234_5678,28'h10,0);
      // write target 0, ack high: rdata must become 0 despite nonzero bus data
      add(0,1,1,32'h0000_0004,32'hA5A5_A5A5,32'hCAFE_F00D,1, 0,0,1,4'b0001,32'h1234_5678,28'h4,1);
      add(0,0,1,32'h0000_0004,32'hA5A5_A5A5,32'hCAFE_F00D,1, 0,0,1,4'b0001,32'h1234_5678,28'h4,1);
      add(0,0,1,32'h0000_0004,32'hA5A5_A5A5,32'hCAFE_F00D,1, 1,0,1,4'b0000,32'h0,28'h4,1);
      add(0,0,0,32'h0000_0004,32'h0,32'h0,0,   0,0,0,4'b0000,32'h0,28'h4,1);
      // timeout on target 1: DONE at edge+17
      add(0,1,0,32'h1000_0020,32'h0,32'h0,0,   0,0,1,4'b0010,32'h0,28'h20,0);
      for (int i = 0; i < 15; i++)
         add(0,0,0,32'h1000_0020,32'h0,32'h0,0, 0,0,1,4'b0010,32'h0,28'h20,0);
      add(0,0,0,32'h1000_0020,32'h0,32'h0,0,   1,1,1,4'b0000,32'hDEADBEEF,28'h20,0);
      add(0,0,0,32'h1000_0020,32'h0,32'h0,0,   0,1,0,4'b0000,32'hDEADBEEF,28'h20,0);

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr;
         wdata = tbl[i].wdata; prdata = tbl[i].prdata; ack = tbl[i].ack;
         step();
         chk($sformatf("v%0d ready", i), {31'd0, ready0}, {31'd0, tbl[i].e_ready});
         chk($sformatf("v%0d err", i),   {31'd0, err0},   {31'd0, tbl[i].e_err});
         chk($sformatf("v%0d busy", i),  {31'd0, busy0},  {31'd0, tbl[i].e_busy});
         chk($sformatf("v%0d ovr", i),   {31'd0, ovr0},   32'd0);
         chk($sformatf("v%0d sel", i),   {28'd0, sel0},   {28'd0, tbl[i].e_sel});
         chk($sformatf("v%0d rdata", i), rdata0,          tbl[i].e_rdata);
         chk($sformatf("v%0d paddr", i), {4'd0, paddr0},  {4'd0, tbl[i].e_paddr});
         chk($sformatf("v%0d pwe", i),   {31'd0, pwe0},   {31'd0, tbl[i].e_pwe});
      end

      // WAIT_CYCLES=2 write: ack at edge+2 is early and ignored, ready at edge+4
      rst = 1'b1; req = 1'b0; ack = 1'b0; step();
      rst = 1'b0; step();
      req = 1'b1; we = 1'b1; addr = 32'h0000_0004; wdata = 32'hA5A5_A5A5; prdata = 32'hFFFF_FFFF;
      step();                                                 // edge+1
      req = 1'b0; we = 1'b0; addr = 32'h3FFF_FFFF; wdata = 32'h0;
      chk("w2 n1 sel", {28'd0, sel1}, 32'h1);
      chk("w2 n1 pwe", {31'd0, pwe1}, 32'h1);
      chk("w2 n1 pwdata", pwdata1, 32'hA5A5_A5A5);
      step();                                                 // edge+2
      ack = 1'b1;
      chk("w2 n2 pwdata", pwdata1, 32'hA5A5_A5A5);
      chk("w2 n2 ready", {31'd0, ready1}, 32'h0);
      step();                                                 // edge+3
      chk("w2 n3 ready (early ack)", {31'd0, ready1}, 32'h0);
      chk("w2 n3 pwe", {31'd0, pwe1}, 32'h1);
      chk("w2 n3 pwdata", pwdata1, 32'hA5A5_A5A5);
      chk("w2 n3 paddr", {4'd0, paddr1}, 32'h4);
      step();                                                 // edge+4
      ack = 1'b0;
      chk("w2 n4 ready", {31'd0, ready1}, 32'h1);
      chk("w2 n4 rdata", rdata1, 32'h0);
      chk("w2 n4 err", {31'd0, err1}, 32'h0);

      // three edges during one long access on the WAIT_CYCLES=1 instance
      rst = 1'b1; step();
      rst = 1'b0; step();
      req = 1'b1; we = 1'b0; addr = 32'h1000_0000; step();   // edge1 at N, now N+1
      req = 1'b0; step();                                     // N+2
      req = 1'b1; addr = 32'h3000_0040; step();               // edge2, now N+3
      req = 1'b0;
      chk("ovr busy", {31'd0, busy0}, 32'h1);
      chk("ovr not yet", {31'd0, ovr0}, 32'h0);
      step();                                                 // N+4
      req = 1'b1; addr = 32'h2000_0000; step();               // edge3, now N+5
      req = 1'b0;
      chk("ovr set", {31'd0, ovr0}, 32'h1);
      n = 5;
      while (!ready0 && n < 40) begin step(); n++; end
      chk("ovr first done cycle", n, 17);
      chk("ovr first err", {31'd0, err0}, 32'h1);
      step();                                                 // N+18: IDLE, slot full
      chk("ovr idle sel", {28'd0, sel0}, 32'h0);
      chk("ovr idle busy", {31'd0, busy0}, 32'h1);
      step();                                                 // N+19: slot served
      chk("ovr second sel", {28'd0, sel0}, 32'h8);
      chk("ovr second paddr", {4'd0, paddr0}, 32'h40);
      ack = 1'b1; prdata = 32'h55AA_33CC;
      n = 0;
      while (!ready0 && n < 10) begin step(); n++; end
      chk("ovr second done cycles", n, 2);
      chk("ovr second rdata", rdata0, 32'h55AA_33CC);
      chk("ovr second err", {31'd0, err0}, 32'h0);
      ack = 1'b0;
      step();
      chk("ovr third dropped busy", {31'd0, busy0}, 32'h0);
      chk("ovr sticky", {31'd0, ovr0}, 32'h1);

      // reset mid-access with a filled slot and i_req held high through reset
      req = 1'b1; addr = 32'h0000_0100; wdata = 32'h1111_2222; we = 1'b1; step();
      chk("rst pre sel", {28'd0, sel0}, 32'h1);
      chk("rst pre pwdata", pwdata0, 32'h1111_2222);
      req = 1'b0; step();
      req = 1'b1; addr = 32'h2000_0200; step();               // slot filled
      rst = 1'b1; step();
      n = 0;
      chk("rst rdata", rdata0, 32'h0);
      chk("rst ready", {31'd0, ready0}, 32'h0);
      chk("rst err", {31'd0, err0}, 32'h0);
      chk("rst busy", {31'd0, busy0}, 32'h0);
      chk("rst ovr", {31'd0, ovr0}, 32'h0);
      chk("rst sel", {28'd0, sel0}, 32'h0);
      chk("rst pwe", {31'd0, pwe0}, 32'h0);
      chk("rst paddr", {4'd0, paddr0}, 32'h0);
      chk("rst pwdata", pwdata0, 32'h0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ready0 || busy0 || sel0 != 4'b0) n++;
      end
      chk("rst held req no start", n, 0);
      req = 1'b0; step();
      req = 1'b1; step();
      chk("rst new edge sel", {28'd0, sel0}, 32'h4);
      chk("rst new edge paddr", {4'd0, paddr0}, 32'h200);
      chk("rst new edge busy", {31'd0, busy0}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
